mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port 1024x16 block RAM (addra/dina/wea/douta) between the instruction-fetch path and the data-memory path of the 16-bit processor.
- Selects one requester per cycle and drives the RAM port.
- Tracks in-flight reads and returns read data to the correct requester after the RAM read latency.
- Sits between the fetch/control unit and the memory core generator block.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (legal values 1 or 2).
- STARVE_LIM, 3, number of consecutive data grants allowed while fetch waits before fetch is forced.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  discard in-flight fetch reads (branch taken).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  data read data valid.
- dm_rdata  out  DATA_W  data read data.
- addra  out  ADDR_W  RAM address.
- dina  out  DATA_W  RAM write data.
- wea  out  1  RAM write enable.
- ena  out  1  RAM enable.
- douta  in  DATA_W  RAM read data.
- stat_conflicts  out  16  cycles where both requests were pending.

Behaviour:
- Reset: all outputs 0. The read-tracking pipe and the starvation counter are cleared.
- Reads issued before reset never produce an rvalid after reset deasserts.
- Grant is combinational within cycle t. The selected requester's addr, wdata and we drive addra, dina and wea. ena=1 when either gnt is high, else ena=0 and wea=0.
- At most one of if_gnt and dm_gnt is high in any cycle.
- Priority:
  - dm_req wins by default.
  - if_req wins when starve_cnt == STARVE_LIM.
  - If only one request is present, that requester is granted.
- starve_cnt (2+ bits, saturating):
  - Increments when dm is granted while if_req=1.
  - Clears when if is granted or if_req=0.
- Read tracking: every granted read pushes {valid, owner} into an RD_LAT-deep shift register.
  - At t+RD_LAT the matching rvalid pulses for one cycle.
  - The matching rdata = douta, registered or passed through consistently for the RAM latency.
  - Non-owner rdata holds its last value.
  - Writes complete on gnt and never pulse rvalid.
- if_flush=1 at cycle t clears valid on every fetch entry in the pipe, including a fetch granted in cycle t. Data entries are unaffected. if_flush does not block new grants in t+1.
- Back-to-back reads: one per cycle, full throughput, with no bubble between alternating owners.
- Requesters must hold req, addr, we and wdata stable until gnt. Behaviour is undefined otherwise.
- stat_conflicts behaviour is defined under Optional Feature.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: stat_conflicts increments every cycle with if_req & dm_req. It saturates at 16'hFFFF and resets to 0.
- Undefined: stat_conflicts is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package mem_arb_pkg holds:
  - owner encoding OWNER_IF=1'b0, OWNER_DM=1'b1;
  - ADDR_W/DATA_W defaults;
  - STARVE_LIM default;
  - the track-entry struct {valid, owner}.
- One sub-module, mem_rd_tracker: the RD_LAT-deep {valid, owner} shift register with a flush-by-owner input.
- Arbitration and the starvation counter stay in mem_arbiter.

Test Plan:
- Reset, then if_req=1, if_addr=10'h005, RAM[5]=16'hA5A5 → if_gnt in the same cycle; if_rvalid=1 with if_rdata=16'hA5A5 RD_LAT cycles later; dm_* outputs stay 0.
- dm_we=1, dm_addr=10'h010, dm_wdata=16'h1234, then a dm read of 10'h010 → write: dm_gnt=1, wea=1, no rvalid; read: dm_rvalid=1 with 16'h1234.
- if_req and dm_req held high continuously (dm reads) → grant sequence DM,DM,DM,IF,DM,DM,DM,IF… with STARVE_LIM=3; if_rvalid and dm_rvalid match their owners; stat_conflicts counts each cycle under MEM_ARB_STATS_EN.
- Fetch granted at cycle t, if_flush=1 at t → no if_rvalid at t+RD_LAT; a dm read granted at t-1 still returns dm_rvalid.
- Reads in flight, reset asserted mid-operation for 1 cycle → all outputs 0 immediately; no rvalid after release.
- Alternating single requests IF@0x001, DM@0x002, IF@0x003 on consecutive cycles → three rvalids on consecutive cycles, owners and data correct, ena high for 3 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the block-RAM arbiter between fetch and data paths.
// Owner encoding and the read-tracking entry live here so tracker and top agree.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 16;
  localparam int RD_LAT_DEF     = 1;
  localparam int STARVE_LIM_DEF = 3;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } track_entry_t;

endpackage

// File: rtl/mem_rd_tracker.sv
// RD_LAT-deep {valid, owner} shift register following reads through the RAM.
// flush_if_i kills every fetch entry, including the one being pushed this cycle.
module mem_rd_tracker
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_valid_i,
  input  owner_e       push_owner_i,
  input  logic         flush_if_i,
  output track_entry_t head_o
);

  track_entry_t [RD_LAT-1:0] pipe_q;
  track_entry_t [RD_LAT-1:0] pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    pipe_d[0].valid = push_valid_i & ~(flush_if_i & (push_owner_i == OWNER_IF));
    pipe_d[0].owner = push_owner_i;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
      if (flush_if_i && (pipe_q[i-1].owner == OWNER_IF)) begin
        pipe_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // The oldest entry lines up with douta for the read it describes.
  assign head_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port block-RAM arbiter: data path wins unless fetch has been starved.
// Define MEM_ARB_STATS_EN to build the stat_conflicts counter; otherwise it reads 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              wea,
  output logic              ena,
  input  logic [DATA_W-1:0] douta,
  output logic [15:0]       stat_conflicts
);

  localparam int SC_W = (STARVE_LIM < 3) ? 2 : $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);

  logic [SC_W-1:0]   starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  track_entry_t      head;
  logic              push_valid;
  owner_e            push_owner;

  // Handshake: a requester holds req/addr/we/wdata until its gnt; gnt is the
  // single-cycle accept, and rvalid later pulses once per accepted read.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (reset) begin
      if (if_req && (!dm_req || (starve_q == STARVE_MAX))) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ena   = if_gnt | dm_gnt;
    wea   = dm_gnt & dm_we;
    addra = '0;
    dina  = '0;
    if (dm_gnt) begin
      addra = dm_addr;
      dina  = dm_we ? dm_wdata : '0;
    end else if (if_gnt) begin
      addra = if_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (dm_gnt && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign push_valid = if_gnt | (dm_gnt & ~dm_we);
  assign push_owner = dm_gnt ? OWNER_DM : OWNER_IF;

  mem_rd_tracker #(
    .RD_LAT(RD_LAT)
  ) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .push_valid_i(push_valid),
    .push_owner_i(push_owner),
    .flush_if_i  (if_flush),
    .head_o      (head)
  );

  assign if_rvalid = head.valid & (head.owner == OWNER_IF);
  assign dm_rvalid = head.valid & (head.owner == OWNER_DM);

  // douta is passed straight through on the returning cycle; the copy kept
  // here only serves to hold the last value while the other owner is served.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= douta;
      if (dm_rvalid) dm_rdata_q <= douta;
    end
  end

  assign if_rdata = if_rvalid ? douta : if_rdata_q;
  assign dm_rdata = dm_rvalid ? douta : dm_rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_q <= '0;
    end else if (if_req && dm_req && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_conflicts = stat_q;
`else
  assign stat_conflicts = '0;
`endif

endmodule
